// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, MMIO register offsets and STATUS bit indices for dmem_responder
package dmem_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 32;

  localparam logic [AW-1:0] MMIO_BASE = 10'h3F0;

  typedef enum logic [3:0] {
    REG_CYCLE     = 4'h0,
    REG_GPIO_OUT  = 4'h1,
    REG_TIMER_CMP = 4'h2,
    REG_STATUS    = 4'h3
  } reg_off_e;

  localparam int STATUS_IRQ = 0;
  localparam int STATUS_ERR = 1;

  // The window is the top 16 words, so only the upper address bits need comparing.
  function automatic logic in_mmio(input logic [AW-1:0] addr);
    return addr[AW-1:4] == MMIO_BASE[AW-1:4];
  endfunction

endpackage

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - CYCLE/GPIO_OUT/TIMER_CMP/STATUS register block, built only with DMEM_MMIO_EN
module dmem_mmio
  import dmem_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    off_i,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          err_set_i,
  output logic [DW-1:0] rdata_o,
  output logic [DW-1:0] gpio_o,
  output logic          irq_o,
  output logic          err_o
);

  logic [DW-1:0] cycle_q, cycle_d;
  logic [DW-1:0] gpio_q, gpio_d;
  logic [DW-1:0] tcmp_q, tcmp_d;
  logic [1:0]    status_q, status_d;

  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    gpio_d   = gpio_q;
    tcmp_d   = tcmp_q;
    status_d = status_q;
    if (we_i) begin
      case (off_i)
        REG_GPIO_OUT:  gpio_d = wdata_i;
        REG_TIMER_CMP: tcmp_d = wdata_i;
        REG_STATUS:    status_d = status_q & ~wdata_i[1:0];
        default:       ;
      endcase
    end
    // Set sources are applied after the write-1-to-clear so a coincident set wins.
    if (cycle_q == tcmp_q) status_d[STATUS_IRQ] = 1'b1;
    if (err_set_i)         status_d[STATUS_ERR] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q  <= '0;
      gpio_q   <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      status_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      gpio_q   <= gpio_d;
      tcmp_q   <= tcmp_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      REG_CYCLE:     rdata_o = cycle_q;
      REG_GPIO_OUT:  rdata_o = gpio_q;
      REG_TIMER_CMP: rdata_o = tcmp_q;
      REG_STATUS:    rdata_o = {30'd0, status_q};
      default:       rdata_o = '0;
    endcase
  end

  assign gpio_o = gpio_q;
  assign irq_o  = status_q[STATUS_IRQ];
  assign err_o  = status_q[STATUS_ERR];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 1024x32 data memory with loader port; DMEM_MMIO_EN maps registers at 0x3F0-0x3FF
module dmem_responder
  import dmem_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] daddr,
  input  logic          d_r,
  input  logic          d_w,
  input  logic [DW-1:0] ddata_w,
  output logic [DW-1:0] ddata_r,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] gpio_out,
  output logic          irq,
  output logic          err
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mmio_rdata;
  logic          hit_mmio;
  logic          ld_hit_mmio;
  logic          err_set;
  logic          cpu_we;
  logic          ld_we;

  // CPU writes always win the single write port; the loader simply waits.
  assign ld_ready = ld_valid & ~d_w & ~RST;
  assign err_set  = d_r & d_w & ~RST;

`ifdef DMEM_MMIO_EN
  assign hit_mmio    = in_mmio(daddr);
  assign ld_hit_mmio = in_mmio(ld_addr);

  dmem_mmio u_mmio (
    .clk_i     (CLK),
    .rst_i     (RST),
    .off_i     (daddr[3:0]),
    .we_i      (d_w & ~RST & hit_mmio),
    .wdata_i   (ddata_w),
    .err_set_i (err_set),
    .rdata_o   (mmio_rdata),
    .gpio_o    (gpio_out),
    .irq_o     (irq),
    .err_o     (err)
  );
`else
  logic err_q, err_d;

  assign hit_mmio    = 1'b0;
  assign ld_hit_mmio = 1'b0;
  assign mmio_rdata  = '0;
  assign gpio_out    = '0;
  assign irq         = 1'b0;

  // No STATUS register here, so the sticky error only clears on reset.
  assign err_d = err_q | err_set;

  always_ff @(posedge CLK) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  // Loader writes into the register window are acknowledged but dropped.
  assign cpu_we = d_w & ~RST & ~hit_mmio;
  assign ld_we  = ld_ready & ~ld_hit_mmio;

  always_ff @(posedge CLK) begin
    if (cpu_we) begin
      mem_q[daddr] <= ddata_w;
    end else if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    ddata_r = '0;
    if (d_r) begin
      ddata_r = hit_mmio ? mmio_rdata : mem_q[daddr];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder; define DMEM_MMIO_EN to exercise the register window
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  daddr;
  logic        d_r;
  logic        d_w;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;
  logic        ld_valid;
  logic        ld_ready;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] gpio_out;
  logic        irq;
  logic        err;

  dmem_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .daddr    (daddr),
    .d_r      (d_r),
    .d_w      (d_w),
    .ddata_w  (ddata_w),
    .ddata_r  (ddata_r),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .gpio_out (gpio_out),
    .irq      (irq),
    .err      (err)
  );

  always #5 CLK = ~CLK;

`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        ldr;
    logic [31:0] gpio;
    logic        irq;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: words known to the bench, plus the register file seen by the CPU.
  logic [31:0] m_ram [int];
  logic [31:0] m_cyc  = 32'd0;
  logic [31:0] m_gpio = 32'd0;
  logic [31:0] m_tcmp = 32'hFFFF_FFFF;
  logic        m_irq  = 1'b0;
  logic        m_err  = 1'b0;

  function automatic logic is_mmio(input logic [9:0] a);
    return MMIO_ON && (a >= 10'h3F0);
  endfunction

  function automatic logic [31:0] mmio_read(input logic [9:0] a);
    case (a[3:0])
      4'h0:    return m_cyc;
      4'h1:    return m_gpio;
      4'h2:    return m_tcmp;
      4'h3:    return {30'd0, m_err, m_irq};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [9:0] pick_addr();
    logic [9:0] a;
    if ($urandom_range(0, 3) == 0) a = 10'h3F0 + 10'($urandom_range(0, 15));
    else                           a = 10'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs, then advance the model across the clock edge.
  task automatic step(output logic acc);
    exp_t e;
    logic set_irq;
    logic nirq;
    logic nerr;
    acc      = ld_valid && !d_w && !RST;
    e.ldr    = acc;
    e.chk_rd = 1'b1;
    e.rd     = 32'd0;
    if (d_r) begin
      if (is_mmio(daddr))                 e.rd = mmio_read(daddr);
      else if (m_ram.exists(int'(daddr))) e.rd = m_ram[int'(daddr)];
      else                                e.chk_rd = 1'b0;
    end
    e.gpio = m_gpio;
    e.irq  = m_irq;
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge CLK);
    if (RST) begin
      m_cyc  = 32'd0;
      m_gpio = 32'd0;
      m_tcmp = 32'hFFFF_FFFF;
      m_irq  = 1'b0;
      m_err  = 1'b0;
    end else begin
      set_irq = MMIO_ON && (m_cyc == m_tcmp);
      nirq    = m_irq;
      nerr    = m_err;
      if (d_w && is_mmio(daddr)) begin
        case (daddr[3:0])
          4'h1: m_gpio = ddata_w;
          4'h2: m_tcmp = ddata_w;
          4'h3: begin
            if (ddata_w[0]) nirq = 1'b0;
            if (ddata_w[1]) nerr = 1'b0;
          end
          default: ;
        endcase
      end
      if (set_irq)    nirq = 1'b1;
      if (d_r && d_w) nerr = 1'b1;
      m_irq = nirq;
      m_err = nerr;
      if (d_w) begin
        if (!is_mmio(daddr)) m_ram[int'(daddr)] = ddata_w;
      end else if (acc && !is_mmio(ld_addr)) begin
        m_ram[int'(ld_addr)] = ld_data;
      end
      m_cyc = m_cyc + 32'd1;
    end
    #1;
  endtask

  task automatic cpu(input logic r, input logic w, input logic [9:0] a, input logic [31:0] wd);
    logic acc;
    d_r     = r;
    d_w     = w;
    daddr   = a;
    ddata_w = wd;
    step(acc);
  endtask

  task automatic rst_pulse();
    RST = 1'b1;
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.chk_rd) chk("ddata_r", ddata_r, e.rd);
      chk("ld_ready", 32'(ld_ready), 32'(e.ldr));
      chk("gpio_out", gpio_out, e.gpio);
      chk("irq", 32'(irq), 32'(e.irq));
      chk("err", 32'(err), 32'(e.err));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    logic acc;
    logic ld_pend;
    RST      = 1'b1;
    d_r      = 1'b0;
    d_w      = 1'b0;
    daddr    = '0;
    ddata_w  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    @(posedge CLK);
    #1;

    // Reset state, including a loader request that must be refused under reset.
    ld_valid = 1'b1;
    ld_addr  = 10'd2;
    ld_data  = 32'h0BAD_0BAD;
    cpu(1'b0, 1'b1, 10'd4, 32'h1);
    cpu(1'b1, 1'b0, 10'h3F1, 32'd0);
    ld_valid = 1'b0;
    RST = 1'b0;

    // Write/read ordering at word 5.
    cpu(1'b0, 1'b1, 10'd5, 32'h1111_1111);
    cpu(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    cpu(1'b1, 1'b0, 10'd5, 32'd0);

    // Loader blocked by two CPU writes, accepted on the third cycle.
    ld_valid = 1'b1;
    ld_addr  = 10'd7;
    ld_data  = 32'h0000_1234;
    cpu(1'b0, 1'b1, 10'd8, 32'hAAAA_AAAA);
    cpu(1'b0, 1'b1, 10'd9, 32'hBBBB_BBBB);
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    ld_valid = 1'b0;
    cpu(1'b1, 1'b0, 10'd7, 32'd0);

    // Loader then CPU on the same word: the later write wins.
    ld_valid = 1'b1;
    ld_addr  = 10'd10;
    ld_data  = 32'h5555_0000;
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    ld_valid = 1'b0;
    cpu(1'b0, 1'b1, 10'd10, 32'h6666_0000);
    cpu(1'b1, 1'b0, 10'd10, 32'd0);

    // Sticky error and its write-1-to-clear.
    cpu(1'b1, 1'b1, 10'd3, 32'h00C0_FFEE);
    repeat (3) cpu(1'b0, 1'b0, 10'd0, 32'd0);
    cpu(1'b0, 1'b1, 10'h3F3, 32'h2);
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    cpu(1'b1, 1'b0, 10'd3, 32'd0);

    // Timer compare, irq clear, consecutive CYCLE reads.
    rst_pulse();
    cpu(1'b0, 1'b1, 10'h3F2, 32'd20);
    repeat (25) cpu(1'b1, 1'b0, 10'h3F3, 32'd0);
    cpu(1'b0, 1'b1, 10'h3F3, 32'h1);
    cpu(1'b1, 1'b0, 10'h3F0, 32'd0);
    cpu(1'b1, 1'b0, 10'h3F0, 32'd0);
    cpu(1'b0, 1'b1, 10'h3F0, 32'h7777_7777);
    cpu(1'b1, 1'b0, 10'h3FC, 32'd0);

    // GPIO then reset: registers clear, RAM survives.
    cpu(1'b0, 1'b1, 10'h3F1, 32'hA5A5_A5A5);
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    rst_pulse();
    cpu(1'b1, 1'b0, 10'd5, 32'd0);

    // Top-of-memory word, then a loader write aimed at the same address.
    cpu(1'b0, 1'b1, 10'h3F1, 32'h0000_0055);
    cpu(1'b1, 1'b0, 10'h3F1, 32'd0);
    ld_valid = 1'b1;
    ld_addr  = 10'h3F1;
    ld_data  = 32'h0000_0099;
    cpu(1'b0, 1'b0, 10'd0, 32'd0);
    ld_valid = 1'b0;
    cpu(1'b1, 1'b0, 10'h3F1, 32'd0);
    cpu(1'b0, 1'b1, 10'h3FF, 32'hFEED_F00D);
    cpu(1'b1, 1'b0, 10'h3FF, 32'd0);

    // Randomised traffic; a pending loader request holds until the model says it was taken.
    ld_pend = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!ld_pend && $urandom_range(0, 2) == 0) begin
        ld_pend = 1'b1;
        ld_addr = pick_addr();
        ld_data = $urandom;
      end
      ld_valid = ld_pend;
      RST      = ($urandom_range(0, 59) == 0);
      d_r      = 1'($urandom_range(0, 1));
      d_w      = ($urandom_range(0, 4) < 2);
      daddr    = pick_addr();
      if (daddr == 10'h3F2 && $urandom_range(0, 1) == 1)
        ddata_w = m_cyc + 32'($urandom_range(1, 6));
      else
        ddata_w = $urandom;
      step(acc);
      if (acc) ld_pend = 1'b0;
    end

    RST      = 1'b0;
    ld_valid = 1'b0;
    d_r      = 1'b0;
    d_w      = 1'b0;
    step(acc);
    @(negedge CLK);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
